// File: rtl/uart_rx.sv
// 8N1 UART byte receiver: two-flop input synchronizer, mid-bit sampling FSM and a
// single-entry valid/ready holding register with framing-error and overrun pulses.
//  state | meaning
//  IDLE  | line idle, waiting for a low level on rxs
//  START | confirming the start bit at half a bit time
//  DATA  | sampling 8 data bits, LSB first
//  STOP  | sampling the stop bit
//  BREAK | stop bit was low, waiting for the line to return high
module uart_rx #(
    parameter int CLK_HZ = 250000000,
    parameter int BAUD   = 115200
) (
    input  logic       sys_clk_i,
    input  logic       sys_rst_i,
    input  logic       rxd_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    if (CLKS_PER_BIT < 8) begin : g_cfg_check
        $error("uart_rx: CLK_HZ/BAUD must be at least 8");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          rx_meta;
    logic          rxs;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          cnt_clr;
    logic          bit_done;
    logic          deliver;
    logic          frame_err_set;

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            state   <= ST_IDLE;
        end else begin
            rx_meta <= rxd_i;
            rxs     <= rx_meta;
            state   <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        cnt_clr       = 1'b0;
        bit_done      = 1'b0;
        deliver       = 1'b0;
        frame_err_set = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rxs) begin
                    state_next = ST_START;
                    cnt_clr    = 1'b1;
                end
            end
            ST_START: begin
                if (cnt == CNT_HALF) begin
                    cnt_clr    = 1'b1;
                    state_next = rxs ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_clr  = 1'b1;
                    bit_done = 1'b1;
                    if (bit_idx == 3'd7) state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_clr = 1'b1;
                    if (rxs) begin
                        deliver    = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        frame_err_set = 1'b1;
                        state_next    = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (rxs) begin
                    cnt_clr    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            cnt         <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            busy_o      <= (state_next != ST_IDLE);
            frame_err_o <= frame_err_set;
            overrun_o   <= 1'b0;

            if (cnt_clr || state == ST_IDLE || state == ST_BREAK)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);

            if (state == ST_START)
                bit_idx <= '0;
            else if (bit_done)
                bit_idx <= bit_idx + 3'd1;

            if (bit_done)
                shift_reg[bit_idx] <= rxs;

            // An accept in the same cycle as a deliver frees the slot for the new byte.
            if (deliver) begin
                if (!valid_o || ready_i) begin
                    data_o  <= shift_reg;
                    valid_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; each task drives one scenario
// and checks hand-derived expectations inline.
module tb_uart_rx;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       rxd     = 1'b1;
    logic       ready   = 1'b0;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    int vectors     = 0;
    int miscompares = 0;

    uart_rx #(.CLK_HZ(1600), .BAUD(100)) dut (
        .sys_clk_i   (sys_clk),
        .sys_rst_i   (sys_rst),
        .rxd_i       (rxd),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // Event counters sampled mid-cycle; tasks compare deltas across a scenario.
    int         n_vrise   = 0;
    int         n_vhigh   = 0;
    int         n_ferr    = 0;
    int         n_ovr     = 0;
    int         rise_cyc  = 0;
    logic [7:0] rise_data = 8'h00;
    logic       valid_q   = 1'b0;
    always @(negedge sys_clk) begin
        if (frame_err_o) n_ferr = n_ferr + 1;
        if (overrun_o) n_ovr = n_ovr + 1;
        if (valid_o) n_vhigh = n_vhigh + 1;
        if (valid_o && !valid_q) begin
            n_vrise   = n_vrise + 1;
            rise_cyc  = cyc;
            rise_data = data_o;
        end
        valid_q = valid_o;
    end

    // Called 1 time unit after a rising edge; returns at the same phase.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        repeat (16) @(posedge sys_clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (16) @(posedge sys_clk);
            #1;
        end
        rxd = stop_bit;
        repeat (16) @(posedge sys_clk);
        #1;
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset;
        sys_rst = 1'b1;
        rxd     = 1'b1;
        ready   = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        vectors++; if (data_o !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h want 00", data_o); end
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        vectors++; if (frame_err_o !== 1'b0) begin miscompares++; $display("FAIL reset_ferr: got %b want 0", frame_err_o); end
        vectors++; if (overrun_o !== 1'b0) begin miscompares++; $display("FAIL reset_ovr: got %b want 0", overrun_o); end
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        sys_rst = 1'b0;
        idle(5);
    endtask

    task automatic test_single_byte;
        int b_rise, b_high, b_ferr, b_ovr, t0, lat;
        ready  = 1'b1;
        b_rise = n_vrise; b_high = n_vhigh; b_ferr = n_ferr; b_ovr = n_ovr;
        t0     = cyc;
        send_byte(8'hA5, 1'b1);
        idle(4);
        lat = rise_cyc - t0;
        vectors++; if (n_vrise - b_rise !== 1) begin miscompares++; $display("FAIL single_rises: got %0d want 1", n_vrise - b_rise); end
        vectors++; if (rise_data !== 8'hA5) begin miscompares++; $display("FAIL single_data: got %h want a5", rise_data); end
        vectors++; if (lat < 153 || lat > 155) begin miscompares++; $display("FAIL single_latency: got %0d want 154+-1", lat); end
        vectors++; if (n_vhigh - b_high !== 1) begin miscompares++; $display("FAIL single_valid_width: got %0d want 1", n_vhigh - b_high); end
        vectors++; if (n_ferr - b_ferr !== 0) begin miscompares++; $display("FAIL single_ferr: got %0d want 0", n_ferr - b_ferr); end
        vectors++; if (n_ovr - b_ovr !== 0) begin miscompares++; $display("FAIL single_ovr: got %0d want 0", n_ovr - b_ovr); end
    endtask

    task automatic test_back_to_back;
        int b_rise, b_ovr;
        ready  = 1'b0;
        b_rise = n_vrise; b_ovr = n_ovr;
        send_byte(8'h00, 1'b1);
        vectors++; if (valid_o !== 1'b1 || data_o !== 8'h00) begin miscompares++; $display("FAIL b2b_first: got valid %b data %h want 1 00", valid_o, data_o); end
        send_byte(8'hFF, 1'b1);
        idle(4);
        vectors++; if (n_ovr - b_ovr !== 1) begin miscompares++; $display("FAIL b2b_overrun: got %0d want 1", n_ovr - b_ovr); end
        vectors++; if (data_o !== 8'h00) begin miscompares++; $display("FAIL b2b_data_held: got %h want 00", data_o); end
        vectors++; if (n_vrise - b_rise !== 1) begin miscompares++; $display("FAIL b2b_rises: got %0d want 1", n_vrise - b_rise); end
        ready = 1'b1;
        @(posedge sys_clk);
        #1;
        ready = 1'b0;
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL b2b_accept: got valid %b want 0", valid_o); end
        vectors++; if (data_o !== 8'h00) begin miscompares++; $display("FAIL b2b_data_after_accept: got %h want 00", data_o); end
        idle(5);
    endtask

    task automatic test_frame_error;
        int b_rise, b_ferr, lat;
        ready  = 1'b1;
        b_rise = n_vrise; b_ferr = n_ferr;
        send_byte(8'h3C, 1'b0);
        repeat (40) @(posedge sys_clk);
        #1;
        vectors++; if (n_ferr - b_ferr !== 1) begin miscompares++; $display("FAIL ferr_pulse: got %0d want 1", n_ferr - b_ferr); end
        vectors++; if (n_vrise - b_rise !== 0) begin miscompares++; $display("FAIL ferr_no_valid: got %0d want 0", n_vrise - b_rise); end
        vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL ferr_busy_break: got %b want 1", busy_o); end
        rxd = 1'b1;
        lat = 99;
        for (int i = 1; i <= 10; i++) begin
            @(posedge sys_clk);
            #1;
            if (!busy_o) begin
                lat = i;
                break;
            end
        end
        vectors++; if (lat < 2 || lat > 3) begin miscompares++; $display("FAIL ferr_busy_release: got %0d want 2..3", lat); end
        idle(5);
        send_byte(8'h5A, 1'b1);
        idle(4);
        vectors++; if (n_vrise - b_rise !== 1) begin miscompares++; $display("FAIL ferr_next_rises: got %0d want 1", n_vrise - b_rise); end
        vectors++; if (rise_data !== 8'h5A) begin miscompares++; $display("FAIL ferr_next_data: got %h want 5a", rise_data); end
        vectors++; if (n_ferr - b_ferr !== 1) begin miscompares++; $display("FAIL ferr_total: got %0d want 1", n_ferr - b_ferr); end
    endtask

    task automatic test_glitch;
        int b_rise, b_ferr, b_ovr, busy_cnt;
        b_rise = n_vrise; b_ferr = n_ferr; b_ovr = n_ovr;
        busy_cnt = 0;
        rxd = 1'b0;
        for (int i = 0; i < 34; i++) begin
            if (i == 4) rxd = 1'b1;
            @(posedge sys_clk);
            #1;
            if (busy_o) busy_cnt++;
        end
        vectors++; if (busy_cnt < 1 || busy_cnt > 9) begin miscompares++; $display("FAIL glitch_busy: got %0d want 1..9", busy_cnt); end
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL glitch_idle: got %b want 0", busy_o); end
        vectors++; if (n_vrise - b_rise !== 0) begin miscompares++; $display("FAIL glitch_valid: got %0d want 0", n_vrise - b_rise); end
        vectors++; if (n_ferr - b_ferr !== 0) begin miscompares++; $display("FAIL glitch_ferr: got %0d want 0", n_ferr - b_ferr); end
        vectors++; if (n_ovr - b_ovr !== 0) begin miscompares++; $display("FAIL glitch_ovr: got %0d want 0", n_ovr - b_ovr); end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] pat;
        int b_rise, b_ferr;
        pat    = 8'h81;
        ready  = 1'b1;
        b_rise = n_vrise; b_ferr = n_ferr;
        rxd = 1'b0;
        repeat (16) @(posedge sys_clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            rxd = pat[i];
            repeat (16) @(posedge sys_clk);
            #1;
        end
        rxd = pat[3];
        repeat (8) @(posedge sys_clk);
        #1;
        sys_rst = 1'b1;
        rxd     = 1'b1;
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        vectors++; if (data_o !== 8'h00) begin miscompares++; $display("FAIL rstmid_data: got %h want 00", data_o); end
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_valid: got %b want 0", valid_o); end
        vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy: got %b want 0", busy_o); end
        vectors++; if (frame_err_o !== 1'b0 || overrun_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_flags: got ferr %b ovr %b want 0 0", frame_err_o, overrun_o); end
        idle(200);
        vectors++; if (n_vrise - b_rise !== 0) begin miscompares++; $display("FAIL rstmid_no_byte: got %0d want 0", n_vrise - b_rise); end
        vectors++; if (n_ferr - b_ferr !== 0) begin miscompares++; $display("FAIL rstmid_ferr: got %0d want 0", n_ferr - b_ferr); end
        send_byte(8'h81, 1'b1);
        idle(4);
        vectors++; if (n_vrise - b_rise !== 1) begin miscompares++; $display("FAIL rstmid_next_rises: got %0d want 1", n_vrise - b_rise); end
        vectors++; if (rise_data !== 8'h81) begin miscompares++; $display("FAIL rstmid_next_data: got %h want 81", rise_data); end
    endtask

    task automatic test_simultaneous;
        int b_rise, b_ovr;
        ready = 1'b0;
        send_byte(8'h11, 1'b1);
        idle(4);
        vectors++; if (valid_o !== 1'b1 || data_o !== 8'h11) begin miscompares++; $display("FAIL simul_held: got valid %b data %h want 1 11", valid_o, data_o); end
        b_rise = n_vrise; b_ovr = n_ovr;
        // Stop sample lands on the 155th edge after the start bit is driven.
        fork
            send_byte(8'h22, 1'b1);
            begin
                repeat (154) @(posedge sys_clk);
                #1;
                ready = 1'b1;
                @(posedge sys_clk);
                #1;
                ready = 1'b0;
            end
        join
        idle(4);
        vectors++; if (valid_o !== 1'b1) begin miscompares++; $display("FAIL simul_valid: got %b want 1", valid_o); end
        vectors++; if (data_o !== 8'h22) begin miscompares++; $display("FAIL simul_data: got %h want 22", data_o); end
        vectors++; if (n_ovr - b_ovr !== 0) begin miscompares++; $display("FAIL simul_ovr: got %0d want 0", n_ovr - b_ovr); end
        vectors++; if (n_vrise - b_rise !== 0) begin miscompares++; $display("FAIL simul_valid_gap: got %0d want 0", n_vrise - b_rise); end
        ready = 1'b1;
        @(posedge sys_clk);
        #1;
        ready = 1'b0;
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("FAIL simul_final_accept: got %b want 0", valid_o); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_frame_error();
        test_glitch();
        test_reset_mid_frame();
        test_simultaneous();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Byte receiver for the USB UART link: samples the serial input from the USB-UART bridge pin, recovers 8N1 frames and presents each byte on a single-entry valid/ready output. It is the receive-side counterpart of the SoC's UART transmit path. It feeds a host-command consumer, such as a debug or register bridge, that runs in the `sys_clk` domain.

## Interface
- `CLK_HZ`, default 250000000: frequency of `sys_clk_i` in Hz.
- `BAUD`, default 115200: line rate.
  - Derived `CLKS_PER_BIT = CLK_HZ / BAUD`, integer truncation; 2170 at the defaults.
  - `CLKS_PER_BIT` must be ≥ 8.
  - Elaboration fails if `CLKS_PER_BIT < 8`.
- `sys_clk_i` input 1: the only clock.
- `sys_rst_i` input 1: synchronous, active-high reset.
- `rxd_i` input 1: asynchronous serial line, idle high.
- `data_o` output 8: received byte, LSB is the first bit on the wire.
- `valid_o` output 1: `data_o` holds an unconsumed byte.
- `ready_i` input 1: consumer accepts the byte when `valid_o` and `ready_i` are both high.
- `frame_err_o` output 1: one-cycle pulse when the stop bit samples 0.
- `overrun_o` output 1: one-cycle pulse when a completed byte is dropped because the holding register is full.
- `busy_o` output 1: high whenever the FSM is not in IDLE.

## Operation
- **Input synchronisation:** `rxd_i` passes through a 2-flop synchronizer. Both flops reset to 1. All logic uses the synchronized value, called `rxs` below.
- **Baud counter:** reloads to 0 on every state entry and counts up to `CLKS_PER_BIT-1`. Bit index is 3 bits wide.
- **FSM states:**
  - IDLE
    - `rxs`==0 → START, counter cleared.
  - START
    - At count `CLKS_PER_BIT/2 - 1`: if `rxs`==0 → DATA with counter cleared and bit index 0; else → IDLE (glitch rejected, no flag).
  - DATA
    - At count `CLKS_PER_BIT-1`: shift `rxs` into bit[index], LSB first.
    - If index==7 → STOP; else increment index.
  - STOP
    - At count `CLKS_PER_BIT-1`:
      - `rxs`==1 → deliver the byte, then → IDLE.
      - `rxs`==0 → pulse `frame_err_o`, discard the byte, → BREAK.
  - BREAK
    - `rxs`==1 → IDLE.
    - Prevents a held-low break from being received as repeated 0x00 frames.
- **Deliver:**
  - If `valid_o`==0, or `ready_i`==1 in the same cycle, load `data_o` and set `valid_o`=1. A simultaneous accept and deliver leaves `valid_o` high with the new byte.
  - If `valid_o`==1 and `ready_i`==0: the old byte is kept, the new byte is dropped and `overrun_o` pulses.
- **Accept:** when `valid_o`&&`ready_i` with no deliver in the same cycle, `valid_o` goes to 0 on the next cycle. `data_o` holds its value.
- **Reset values:**
  - Outputs: `data_o`=0x00, `valid_o`=0, `frame_err_o`=0, `overrun_o`=0, `busy_o`=0.
  - Internal: FSM=IDLE, shift register=0.
- **Reset mid-frame:** reset takes effect on the next clock edge and aborts the frame. The partial byte is never delivered. After reset, a line still low waits in IDLE and is treated as a new start.

## Timing
- Take cycle 0 as the first edge at which `rxs` is seen low in IDLE. The pad-to-`rxs` delay is 2 cycles.
- Start check at cycle `CLKS_PER_BIT/2`.
- Data bit k is sampled at cycle `CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT`.
- Stop bit is sampled at cycle `CLKS_PER_BIT/2 + 9*CLKS_PER_BIT`.
- `valid_o`, `frame_err_o` and `overrun_o` change on the cycle after the stop sample.
- `busy_o` falls on the same cycle, unless the FSM enters BREAK.
- A new start bit is detected from the first IDLE cycle. Back-to-back frames with exactly one stop bit are received without loss.
- All outputs are registered. There are no combinational paths from `ready_i` or `rxd_i` to any output.
- Tolerated clock mismatch is ±4% at `CLKS_PER_BIT` ≥ 16.

## Test plan
Benches use `CLK_HZ`=1600 and `BAUD`=100, so `CLKS_PER_BIT`=16.
- **Single byte:** drive 0xA5 as 8N1 with `ready_i`=1 → `valid_o` rises for one cycle with `data_o`=0xA5, 154±1 cycles after the falling edge of `rxd_i`. No error pulses.
- **Back-to-back with stall:** send 0x00 then 0xFF back-to-back with `ready_i`=0 → first byte 0x00 held on `data_o`. At the end of the second stop bit `overrun_o` pulses once and `data_o` stays 0x00. Raising `ready_i` clears `valid_o`.
- **Framing error:** send 0x3C with the stop bit low, then hold `rxd_i` low for 40 cycles and release → `frame_err_o` pulses once, `valid_o` stays 0, `busy_o` stays 1 until 2 cycles after release. A following 0x5A frame is received correctly.
- **Glitch:** a 4-cycle low pulse on an idle line → FSM returns to IDLE, `busy_o` high for no more than 9 cycles, no output activity.
- **Reset mid-frame:** assert `sys_rst_i` for 1 cycle during data bit 3 of 0x81, with the line released to idle afterwards → all outputs read 0 on the next cycle and no byte is delivered. A subsequent 0x81 frame is received correctly.
- **Simultaneous accept and deliver:** `valid_o`=1 with 0x11 held, send 0x22, and pulse `ready_i` exactly on the deliver cycle → `valid_o` stays 1, `data_o`=0x22, no `overrun_o`.
